fdiv_issue_ctrl: RTL and testbench

//  Issue/writeback controller directly upstream of DivFPU_FSM for FDIV.S.
//  - Accepts a divide request from the FP execute stage (valid/ready).
//  - Resolves IEEE special operands locally, with no divider trip.
//  - Launches DivFPU_FSM for normal operands and waits for its done.
//  - Returns result, destination tag and fflags to FP writeback (valid/ready).

---
 rtl/fdiv_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_fdiv_issue_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fdiv_issue_ctrl.sv
// FDIV.S issue/writeback controller in front of DivFPU_FSM: resolves IEEE
// special operands locally, launches the divider otherwise, and returns the result.
module fdiv_issue_ctrl #(
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_rd,
   output logic             div_start,
   output logic [31:0]      div_N1,
   output logic [31:0]      div_N2,
   input  logic [31:0]      div_result,
   input  logic             div_done,
   input  logic             div_busy,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [31:0]      wb_data,
   output logic [TAG_W-1:0] wb_rd,
   output logic [4:0]       wb_fflags,
   output logic             busy
);

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [4:0]  FLAG_NV = 5'b10000;
   localparam logic [4:0]  FLAG_DZ = 5'b01000;
   localparam logic [7:0]  CNT_MAX = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

   state_t           state_q;
   logic [31:0]      n1_q, n2_q, data_q;
   logic [TAG_W-1:0] rd_q;
   logic [4:0]       flags_q;
   logic [7:0]       cnt_q;
   logic             wb_valid_q;

   // Denormals (exp==0) are treated as signed zeros.
   function automatic logic is_zero(input logic [31:0] x);
      return x[30:23] == 8'h00;
   endfunction

   function automatic logic is_inf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
   endfunction

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
   endfunction

   function automatic logic is_snan(input logic [31:0] x);
      return is_nan(x) && !x[22];
   endfunction

   logic        sign;
   logic        spec_hit;
   logic [31:0] spec_data;
   logic [4:0]  spec_flags;

   always_comb begin
      sign       = req_a[31] ^ req_b[31];
      spec_hit   = 1'b1;
      spec_data  = QNAN;
      spec_flags = 5'b0;
      if (is_nan(req_a) || is_nan(req_b)) begin
         spec_flags = (is_snan(req_a) || is_snan(req_b)) ? FLAG_NV : 5'b0;
      end else if ((is_zero(req_a) && is_zero(req_b)) || (is_inf(req_a) && is_inf(req_b))) begin
         spec_flags = FLAG_NV;
      end else if (is_zero(req_b)) begin
         spec_data  = {sign, 8'hFF, 23'h0};
         spec_flags = FLAG_DZ;
      end else if (is_inf(req_a)) begin
         spec_data  = {sign, 8'hFF, 23'h0};
      end else if (is_zero(req_a) || is_inf(req_b)) begin
         spec_data  = {sign, 31'h0};
      end else begin
         spec_hit   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         n1_q       <= 32'h0;
         n2_q       <= 32'h0;
         data_q     <= 32'h0;
         rd_q       <= '0;
         flags_q    <= 5'b0;
         cnt_q      <= 8'h0;
         wb_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  rd_q  <= req_rd;
                  cnt_q <= 8'h0;
                  if (spec_hit) begin
                     data_q     <= spec_data;
                     flags_q    <= spec_flags;
                     wb_valid_q <= 1'b1;
                     state_q    <= S_RESP;
                  end else begin
                     n1_q    <= req_a;
                     n2_q    <= req_b;
                     state_q <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               if (!div_busy) state_q <= S_WAIT;
            end
            S_WAIT: begin
               // Completion wins over the watchdog if both land on the same cycle.
               if (div_done) begin
                  data_q     <= div_result;
                  flags_q    <= 5'b0;
                  wb_valid_q <= 1'b1;
                  state_q    <= S_RESP;
               end else if (cnt_q == CNT_MAX) begin
                  data_q     <= QNAN;
                  flags_q    <= FLAG_NV;
                  wb_valid_q <= 1'b1;
                  state_q    <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 8'h1;
               end
            end
            S_RESP: begin
               if (wb_ready) begin
                  wb_valid_q <= 1'b0;
                  cnt_q      <= 8'h0;
                  state_q    <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // The launch pulse must follow div_busy within the LAUNCH cycle itself.
   assign div_start = (state_q == S_LAUNCH) && !div_busy;
   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign div_N1    = n1_q;
   assign div_N2    = n2_q;
   assign wb_valid  = wb_valid_q;
   assign wb_data   = data_q;
   assign wb_rd     = rd_q;
   assign wb_fflags = flags_q;

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Directed testbench for fdiv_issue_ctrl with hand-computed expected values;
// the divider is played by the bench.
module tb_fdiv_issue_ctrl;

   localparam int TAG_W   = 5;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [31:0]      req_a = 32'h0;
   logic [31:0]      req_b = 32'h0;
   logic [TAG_W-1:0] req_rd = '0;
   logic             div_start;
   logic [31:0]      div_N1, div_N2;
   logic [31:0]      div_result = 32'h0;
   logic             div_done = 1'b0;
   logic             div_busy = 1'b0;
   logic             wb_valid;
   logic             wb_ready = 1'b1;
   logic [31:0]      wb_data;
   logic [TAG_W-1:0] wb_rd;
   logic [4:0]       wb_fflags;
   logic             busy;

   int n_pass  = 0;
   int n_total = 0;
   int starts  = 0;

   fdiv_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
      .div_start(div_start), .div_N1(div_N1), .div_N2(div_N2),
      .div_result(div_result), .div_done(div_done), .div_busy(div_busy),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_rd(wb_rd), .wb_fflags(wb_fflags), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (div_start) starts++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single cycle; returns one cycle after acceptance.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] rd);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   task automatic special(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input logic [4:0] exp_f);
      int s0;
      s0 = starts;
      issue(a, b, 5'd9);
      chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, "_data"}, wb_data, exp_d);
      chk({tag, "_flags"}, 32'(wb_fflags), 32'(exp_f));
      chk({tag, "_rd"}, 32'(wb_rd), 32'd9);
      step();
      chk({tag, "_nostart"}, 32'(starts - s0), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      logic [31:0] held;
      step(); step();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_div_N1", div_N1, 32'h0);
      chk("rst_div_start", 32'(div_start), 32'd0);
      rst = 1'b0;
      step();

      // 6.0 / 2.0 through the divider
      issue(32'h40C0_0000, 32'h4000_0000, 5'd7);
      chk("t1_start", 32'(div_start), 32'd1);
      chk("t1_N1", div_N1, 32'h40C0_0000);
      chk("t1_N2", div_N2, 32'h4000_0000);
      chk("t1_busy", 32'(busy), 32'd1);
      step();
      chk("t1_start_low", 32'(div_start), 32'd0);
      step(); step();
      chk("t1_N1_hold", div_N1, 32'h40C0_0000);
      div_done = 1'b1; div_result = 32'h4040_0000;
      step();
      div_done = 1'b0;
      chk("t1_valid", 32'(wb_valid), 32'd1);
      chk("t1_data", wb_data, 32'h4040_0000);
      chk("t1_flags", 32'(wb_fflags), 32'd0);
      chk("t1_rd", 32'(wb_rd), 32'd7);
      chk("t1_ready_resp", 32'(req_ready), 32'd0);
      step();
      chk("t1_done_valid", 32'(wb_valid), 32'd0);
      chk("t1_one_start", 32'(starts), 32'd1);

      special("dz",    32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 5'b01000);
      special("zz",    32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 5'b10000);
      special("snan",  32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 5'b10000);
      special("qnan",  32'h3F80_0000, 32'hFFC0_0000, 32'h7FC0_0000, 5'b00000);
      special("ii",    32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 5'b10000);
      special("fin_i", 32'hC110_0000, 32'h7F80_0000, 32'h8000_0000, 5'b00000);
      special("i_fin", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 5'b00000);
      special("denz",  32'h0000_0001, 32'hC000_0000, 32'h8000_0000, 5'b00000);

      // Divider busy holds LAUNCH; writeback back-pressure holds RESP
      div_busy = 1'b1;
      wb_ready = 1'b0;
      issue(32'h4100_0000, 32'h4080_0000, 5'd21);
      chk("t5_hold_nostart", 32'(div_start), 32'd0);
      step();
      chk("t5_hold_nostart2", 32'(div_start), 32'd0);
      div_busy = 1'b0;
      #1;
      chk("t5_start", 32'(div_start), 32'd1);
      step();
      div_done = 1'b1; div_result = 32'h4000_0000;
      step();
      div_done = 1'b0;
      held = wb_data;
      chk("t5_data", held, 32'h4000_0000);
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_a = 32'h3F80_0000; req_b = 32'h0;
         chk("t5_valid_hold", 32'(wb_valid), 32'd1);
         chk("t5_data_hold", wb_data, 32'h4000_0000);
         chk("t5_rd_hold", 32'(wb_rd), 32'd21);
         chk("t5_ready_low", 32'(req_ready), 32'd0);
         step();
      end
      req_valid = 1'b0;
      wb_ready = 1'b1;
      step();
      chk("t5_released", 32'(wb_valid), 32'd0);
      chk("t5_idle", 32'(req_ready), 32'd1);

      // Reset in WAIT, then a late div_done must be ignored
      issue(32'h4040_0000, 32'h3F80_0000, 5'd3);
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_N1", div_N1, 32'h0);
      div_done = 1'b1; div_result = 32'h1234_5678;
      step();
      div_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t6_no_wb", 32'(wb_valid), 32'd0);
         chk("t6_idle", 32'(req_ready), 32'd1);
         step();
      end

      // Watchdog: divider never answers
      issue(32'h4040_0000, 32'h3F80_0000, 5'd12);
      chk("t7_start", 32'(div_start), 32'd1);
      step();
      n = 0;
      while (!wb_valid && n < 100) begin
         step();
         n++;
      end
      chk("t7_cycles", 32'(n), 32'(TIMEOUT));
      chk("t7_data", wb_data, 32'h7FC0_0000);
      chk("t7_flags", 32'(wb_fflags), 32'h10);
      chk("t7_rd", 32'(wb_rd), 32'd12);
      step();
      chk("t7_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
